// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the clock_ctrl slice: CPU state encoding and widths.
package clock_ctrl_pkg;

  // Width of the cpu_ce pulse counter.
  localparam int unsigned CLOCK_CTRL_CC_W = 32;

  // CPU clock-enable controller states.
  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StHalt = 2'd1,
    StStep = 2'd2
  } cpu_state_e;

endpackage

// File: rtl/clock_ctrl_div.sv
// Single auxiliary divider channel: programmable tick pulse and toggle output.
// A period of 0 parks the channel with its toggle level frozen.
module clock_ctrl_div
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] period,
  output logic             tick,
  output logic             toggle
);

  logic [DIV_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             toggle_q, toggle_d;

  // Next-state: >= compare lets a shortened period take effect immediately.
  always_comb begin
    count_d  = count_q;
    tick_d   = 1'b0;
    toggle_d = toggle_q;
    if (period == '0) begin
      count_d = '0;
    end else if (count_q >= period) begin
      count_d  = '0;
      tick_d   = 1'b1;
      toggle_d = ~toggle_q;
    end else begin
      count_d = count_q + DIV_W'(1);
    end
  end

  // Channel state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      tick_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      tick_q   <= tick_d;
      toggle_q <= toggle_d;
    end
  end

  assign tick   = tick_q;
  assign toggle = toggle_q;

endmodule

// File: rtl/clock_ctrl.sv
// Core-domain clock-enable and debug-stepping controller.
// Produces the CPU clock-enable with run/halt/single-step and PC breakpoint,
// plus NUM_DIV programmable auxiliary tick/toggle channels.
// Optional: CLOCK_CTRL_CYCLE_COUNT_EN adds a 32-bit cpu_ce pulse counter;
// without it cycle_count is tied to zero.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIV = 2,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned CPU_DIV = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_DIV*DIV_W-1:0]   div_period,
  output logic [NUM_DIV-1:0]         tick,
  output logic [NUM_DIV-1:0]         toggle,
  input  logic                       step_enable,
  input  logic                       step_req,
  input  logic                       run_req,
  input  logic                       bp_en,
  input  logic [15:0]                bp_addr,
  input  logic [15:0]                pc,
  output logic                       cpu_ce,
  output logic                       halted,
  output logic                       bp_hit,
  output logic [CLOCK_CTRL_CC_W-1:0] cycle_count
);

  localparam int unsigned PhaseW = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(CPU_DIV - 1);

  // Auxiliary divider channels.
  for (genvar g = 0; g < NUM_DIV; g++) begin : g_div
    clock_ctrl_div #(
      .DIV_W (DIV_W)
    ) u_div (
      .clock  (clock),
      .reset  (reset),
      .period (div_period[g*DIV_W +: DIV_W]),
      .tick   (tick[g]),
      .toggle (toggle[g])
    );
  end

  logic [PhaseW-1:0] phase_q, phase_d;
  logic              boundary;
  logic              step_prev_q;
  logic              step_rise;
  cpu_state_e        state_q, state_d;
  logic              cpu_ce_q, cpu_ce_d;
  logic              bp_hit_q, bp_hit_d;
  logic              halted_q;

  assign boundary  = (phase_q == PhaseLast);
  assign step_rise = step_req & ~step_prev_q;

  // Phase counter free-runs in every state.
  always_comb begin
    phase_d = boundary ? '0 : phase_q + PhaseW'(1);
  end

  // Run/halt/step next-state and CPU enable decode.
  always_comb begin
    state_d  = state_q;
    cpu_ce_d = 1'b0;
    bp_hit_d = bp_hit_q;
    case (state_q)
      StRun: begin
        if (boundary) begin
          // Breakpoint wins over step_enable; both swallow this enable.
          if (bp_en && (pc == bp_addr)) begin
            state_d  = StHalt;
            bp_hit_d = 1'b1;
          end else if (step_enable) begin
            state_d = StHalt;
          end else begin
            cpu_ce_d = 1'b1;
          end
        end
      end
      StHalt: begin
        if (run_req && !step_enable) begin
          state_d  = StRun;
          bp_hit_d = 1'b0;
        end else if (step_rise) begin
          state_d = StStep;
        end
      end
      StStep: begin
        // One instruction issued regardless of the breakpoint.
        if (boundary) begin
          cpu_ce_d = 1'b1;
          state_d  = StHalt;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q     <= '0;
      step_prev_q <= 1'b0;
      state_q     <= StRun;
      cpu_ce_q    <= 1'b0;
      bp_hit_q    <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      step_prev_q <= step_req;
      state_q     <= state_d;
      cpu_ce_q    <= cpu_ce_d;
      bp_hit_q    <= bp_hit_d;
      halted_q    <= (state_d == StHalt);
    end
  end

  assign cpu_ce = cpu_ce_q;
  assign halted = halted_q;
  assign bp_hit = bp_hit_q;

`ifdef CLOCK_CTRL_CYCLE_COUNT_EN
  logic [CLOCK_CTRL_CC_W-1:0] cycle_count_q;

  // Counts issued enables; updates together with cpu_ce so the value includes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_count_q <= '0;
    end else if (cpu_ce_d) begin
      cycle_count_q <= cycle_count_q + CLOCK_CTRL_CC_W'(1);
    end
  end

  assign cycle_count = cycle_count_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model of the controller.
module tb_clock_ctrl;

  localparam int unsigned NUM_DIV = 2;
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned CPU_DIV = 8;

  localparam int ModeRun  = 0;
  localparam int ModeHalt = 1;
  localparam int ModeStep = 2;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_DIV*DIV_W-1:0] div_period;
  logic [NUM_DIV-1:0]       tick;
  logic [NUM_DIV-1:0]       toggle;
  logic                     step_enable;
  logic                     step_req;
  logic                     run_req;
  logic                     bp_en;
  logic [15:0]              bp_addr;
  logic [15:0]              pc;
  logic                     cpu_ce;
  logic                     halted;
  logic                     bp_hit;
  logic [31:0]              cycle_count;

  always #5 clock = ~clock;

  clock_ctrl #(
    .NUM_DIV (NUM_DIV),
    .DIV_W   (DIV_W),
    .CPU_DIV (CPU_DIV)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .div_period  (div_period),
    .tick        (tick),
    .toggle      (toggle),
    .step_enable (step_enable),
    .step_req    (step_req),
    .run_req     (run_req),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .cpu_ce      (cpu_ce),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .cycle_count (cycle_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: time is cycles since reset release.
  longint      m_cycles;
  int          m_mode;
  bit          m_ce;
  bit          m_bp;
  bit          m_prev_step;
  logic [31:0] m_cc;
  int          m_cnt  [NUM_DIV];
  bit          m_tick [NUM_DIV];
  bit          m_tog  [NUM_DIV];
  longint      last_ce;
  longint      first_ce;
  int          ce_seen;
  int          tick_seen [NUM_DIV];

  task automatic model_reset();
    m_cycles    = 0;
    m_mode      = ModeRun;
    m_ce        = 0;
    m_bp        = 0;
    m_prev_step = 0;
    m_cc        = '0;
    last_ce     = -1;
    first_ce    = -1;
    for (int i = 0; i < NUM_DIV; i++) begin
      m_cnt[i]  = 0;
      m_tick[i] = 0;
      m_tog[i]  = 0;
    end
  endtask

  task automatic model_clock();
    bit boundary;
    bit rise;
    int p;
    boundary = (m_cycles % longint'(CPU_DIV)) == longint'(CPU_DIV - 1);
    rise     = step_req && !m_prev_step;
    m_ce     = 0;
    if (m_mode == ModeRun) begin
      if (boundary) begin
        if (bp_en && pc == bp_addr) begin
          m_mode = ModeHalt;
          m_bp   = 1;
        end else if (step_enable) begin
          m_mode = ModeHalt;
        end else begin
          m_ce = 1;
        end
      end
    end else if (m_mode == ModeHalt) begin
      if (run_req && !step_enable) begin
        m_mode = ModeRun;
        m_bp   = 0;
      end else if (rise) begin
        m_mode = ModeStep;
      end
    end else begin
      if (boundary) begin
        m_ce   = 1;
        m_mode = ModeHalt;
      end
    end
    if (m_ce) m_cc = m_cc + 32'd1;
    m_prev_step = step_req;
    m_cycles++;
    for (int i = 0; i < NUM_DIV; i++) begin
      p = int'(div_period[i*DIV_W +: DIV_W]);
      if (p == 0) begin
        m_cnt[i]  = 0;
        m_tick[i] = 0;
      end else if (m_cnt[i] >= p) begin
        m_cnt[i]  = 0;
        m_tick[i] = 1;
        m_tog[i]  = !m_tog[i];
      end else begin
        m_cnt[i]++;
        m_tick[i] = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("cpu_ce", cpu_ce, m_ce);
    check_eq("halted", halted, m_mode == ModeHalt);
    check_eq("bp_hit", bp_hit, m_bp);
`ifdef CLOCK_CTRL_CYCLE_COUNT_EN
    check_eq("cycle_count", cycle_count, m_cc);
`else
    check_eq("cycle_count", cycle_count, 0);
`endif
    for (int i = 0; i < NUM_DIV; i++) begin
      check_eq($sformatf("tick%0d", i), tick[i], m_tick[i]);
      check_eq($sformatf("toggle%0d", i), toggle[i], m_tog[i]);
      if (tick[i]) tick_seen[i]++;
    end
    if (cpu_ce) begin
      ce_seen++;
      if (last_ce >= 0) check_eq("ce_spacing", (m_cycles - last_ce) >= CPU_DIV, 1);
      if (first_ce < 0) first_ce = m_cycles;
      last_ce = m_cycles;
    end
  endtask

  // Inputs only change between the sampling negedge and the next posedge.
  task automatic cycle();
    @(posedge clock);
    if (reset) model_reset();
    else model_clock();
    @(negedge clock);
    compare_outputs();
  endtask

  int snap;
  int t0;
  int gap;

  initial begin
    reset       = 1'b1;
    div_period  = '0;
    step_enable = 1'b0;
    step_req    = 1'b0;
    run_req     = 1'b0;
    bp_en       = 1'b0;
    bp_addr     = 16'h0150;
    pc          = 16'h0000;
    ce_seen     = 0;
    for (int i = 0; i < NUM_DIV; i++) tick_seen[i] = 0;
    model_reset();
    #2;
    check_eq("rst_cpu_ce", cpu_ce, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_tick", tick, 0);
    repeat (3) cycle();

    // Free run with ch0 period 3, ch1 disabled.
    div_period = {16'd0, 16'd3};
    reset      = 1'b0;
    snap = ce_seen;
    t0   = tick_seen[0];
    repeat (64) cycle();
    check_eq("first_ce_latency", first_ce, 8);
    check_eq("free_run_ce_count", ce_seen - snap, 8);
    check_eq("ch0_ticks_64", tick_seen[0] - t0, 16);
    check_eq("ch1_ticks_64", tick_seen[1], 0);
    check_eq("ch1_toggle_low", toggle[1], 0);

    // Shrink ch0 period below its current count.
    div_period[DIV_W-1:0] = 16'd100;
    for (int i = 0; i < 300 && m_cnt[0] != 50; i++) cycle();
    div_period[DIV_W-1:0] = 16'd5;
    cycle();
    check_eq("reduce_tick_next", tick[0], 1);
    gap = 0;
    do begin
      cycle();
      gap++;
    end while (!tick[0] && gap < 20);
    check_eq("reduce_spacing", gap, 6);

    // Breakpoint halt and resume.
    bp_en = 1'b1;
    pc    = 16'h0150;
    for (int i = 0; i < 20 && !halted; i++) cycle();
    check_eq("bp_halted", halted, 1);
    check_eq("bp_hit_set", bp_hit, 1);
    pc = 16'h0200;
    repeat (5) cycle();
    run_req = 1'b1;
    cycle();
    run_req = 1'b0;
    check_eq("bp_resume_halted", halted, 0);
    check_eq("bp_resume_hit", bp_hit, 0);
    bp_en = 1'b0;

    // Single stepping.
    step_enable = 1'b1;
    for (int i = 0; i < 20 && !halted; i++) cycle();
    check_eq("step_mode_halted", halted, 1);
    snap = ce_seen;
    for (int k = 0; k < 3; k++) begin
      step_req = 1'b1;
      repeat (2) cycle();
      step_req = 1'b0;
      repeat (18) cycle();
    end
    check_eq("three_steps", ce_seen - snap, 3);
    snap = ce_seen;
    step_req = 1'b1;
    repeat (40) cycle();
    step_req = 1'b0;
    repeat (10) cycle();
    check_eq("held_step_one_pulse", ce_seen - snap, 1);
    step_enable = 1'b0;
    cycle();
    step_req = 1'b1;
    run_req  = 1'b1;
    cycle();
    step_req = 1'b0;
    run_req  = 1'b0;
    check_eq("run_beats_step", halted, 0);
    repeat (10) cycle();

    // Random stimulus.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 63) == 0) step_enable = ~step_enable;
      if ($urandom_range(0, 127) == 0) bp_en = ~bp_en;
      step_req = ($urandom_range(0, 3) == 0);
      run_req  = ($urandom_range(0, 15) == 0);
      pc       = ($urandom_range(0, 3) == 0) ? bp_addr : 16'($urandom);
      for (int i = 0; i < NUM_DIV; i++)
        if ($urandom_range(0, 99) == 0) div_period[i*DIV_W +: DIV_W] = 16'($urandom_range(0, 12));
      cycle();
    end

    // Reset while stepping aborts at once.
    run_req     = 1'b0;
    bp_en       = 1'b0;
    step_enable = 1'b1;
    step_req    = 1'b0;
    div_period  = {16'd2, 16'd1};
    for (int i = 0; i < 40 && !halted; i++) cycle();
    cycle();
    step_req = 1'b1;
    cycle();
    check_eq("in_step_not_halted", halted, 0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_cpu_ce", cpu_ce, 0);
    check_eq("async_halted", halted, 0);
    check_eq("async_bp_hit", bp_hit, 0);
    check_eq("async_tick", tick, 0);
    check_eq("async_toggle", toggle, 0);
    check_eq("async_cycle_count", cycle_count, 0);
    model_reset();
    step_req    = 1'b0;
    step_enable = 1'b0;
    @(negedge clock);
    repeat (2) cycle();
    reset = 1'b0;
    repeat (20) cycle();
    check_eq("post_reset_first_ce", first_ce, 8);
    check_eq("post_reset_running", halted, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Parametrised clock-enable and debug-stepping controller for the GameBoy core domain.
- Replaces ad-hoc divider, clock-mux and toggle logic with clock-enables derived from one core clock.
- Generates the CPU clock-enable, with run, halt and single-step control plus a PC breakpoint.
- Provides NUM_DIV runtime-programmable auxiliary tick/toggle channels for the joypad, SPI and similar blocks.

Parameters:
- NUM_DIV, 2: number of auxiliary divider channels (1..8).
- DIV_W, 16: auxiliary counter width in bits.
- CPU_DIV, 8: core cycles per CPU enable (2..256).

Ports:
- clock  in  1: core clock; all logic on rising edge.
- reset  in  1: asynchronous, active-high.
- div_period  in  NUM_DIV*DIV_W: channel i period at slice [i*DIV_W +: DIV_W]; 0 disables the channel.
- tick  out  NUM_DIV: one-cycle pulse per channel.
- toggle  out  NUM_DIV: square wave per channel; inverts on each tick.
- step_enable  in  1: level; high requests halt / step mode.
- step_req  in  1: synchronous, pre-debounced step button.
- run_req  in  1: one-cycle pulse; resume from halt.
- bp_en  in  1: breakpoint enable.
- bp_addr  in  16: breakpoint address.
- pc  in  16: current CPU program counter.
- cpu_ce  out  1: registered one-cycle CPU clock-enable.
- halted  out  1: high while state is HALT.
- bp_hit  out  1: sticky breakpoint-hit flag.
- cycle_count  out  32: count of cpu_ce pulses.

Behaviour:
- Reset (async) values:
  - all counters 0; state RUN.
  - cpu_ce 0, tick 0, toggle 0, halted 0, bp_hit 0, cycle_count 0.
  - Reset asserted mid-operation aborts immediately; there is no pending-step memory.
- Phase counter:
  - width clog2(CPU_DIV); counts 0..CPU_DIV-1 and wraps.
  - free-runs in every state.
  - "Boundary" means the cycle in which phase == CPU_DIV-1.
- Aux channel i:
  - On each cycle, if period == 0: count held at 0, tick[i] = 0, toggle[i] held.
  - Otherwise, if count >= period: count <= 0, tick[i] <= 1, toggle[i] inverts.
  - Otherwise: count increments, tick[i] <= 0.
  - Tick spacing is period+1 cycles. The >= compare makes a period reduced below the current count take effect on the next cycle.
- Step edge detection: step_d registered; step_rise = step_req && !step_d.
- State machine, states RUN, HALT, STEP:
  - RUN, at a boundary:
    - If bp_en && pc == bp_addr: go to HALT, set bp_hit, suppress cpu_ce.
    - Else if step_enable: go to HALT, suppress cpu_ce.
    - Else: cpu_ce <= 1.
    - Breakpoint has priority over step_enable; both produce HALT.
  - HALT:
    - run_req && !step_enable: go to RUN, clear bp_hit.
    - Else step_rise: go to STEP.
    - run_req has priority over step_rise in the same cycle.
    - step_enable high blocks run_req.
  - STEP, at the next boundary: cpu_ce <= 1, go to HALT. The breakpoint is ignored for this one instruction cycle.
  - step_rise while in STEP is ignored; there is no queueing.
  - halted = (state == HALT); registered from the state.
- cpu_ce is never high for two consecutive cycles.
- Minimum spacing between cpu_ce pulses is CPU_DIV cycles.

Optional Feature:
- Macro CLOCK_CTRL_CYCLE_COUNT_EN.
- Defined: 32-bit counter increments on every cpu_ce pulse, wraps 0xFFFFFFFF -> 0, and is cleared only by reset.
- Undefined: cycle_count is tied to 0 and no counter flops are present.

Decomposition:
- Shared package clock_ctrl_pkg holds:
  - state encoding: RUN = 2'd0, HALT = 2'd1, STEP = 2'd2.
  - constant CLOCK_CTRL_CC_W = 32.
- One sub-module, clock_ctrl_div: a single aux channel with ports clock, reset, period, tick, toggle. It is instantiated NUM_DIV times in a generate loop.

Test Plan:
- Free run, CPU_DIV=8, no step/bp → cpu_ce every 8 cycles; first pulse 8 cycles after reset release; halted=0.
- div_period ch0=3, ch1=0 → tick[0] every 4 cycles and toggle[0] period 8; tick[1]=0 and toggle[1]=0 throughout.
- Reduce ch0 period 100→5 while count=50 → tick on the next cycle, then every 6 cycles.
- bp_en=1, bp_addr=0x0150, pc driven to 0x0150 → no cpu_ce at that boundary; halted=1 and bp_hit=1 next cycle. run_req with step_enable=0 → RUN, bp_hit=0.
- step_enable=1 → HALT. Three step_req rising edges ≥16 cycles apart → exactly three cpu_ce pulses, each on a boundary. A step_req held high for 40 cycles → one pulse. run_req and step_rise in the same cycle with step_enable=0 → RUN.
- Assert reset during STEP → all outputs 0 immediately, with no clock edge needed. After release: state RUN, and with the macro defined cycle_count restarts from 0.
